// File: rtl/mem_arbiter.sv
// Three-requester round-robin arbiter with lock hold for a single-port program/data RAM.
// Writes below WP_LIMIT (interpreter/font space) are suppressed and flagged on wp_err.
module mem_arbiter #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned WP_LIMIT   = 512
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [2:0]            req,
  input  logic [2:0]            lock,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [ADDR_WIDTH-1:0] addr2,
  input  logic [2:0]            we,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  input  logic [DATA_WIDTH-1:0] wdata2,
  output logic [2:0]            gnt,
  output logic [2:0]            rvalid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [2:0]            wp_err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int unsigned IDX_W = 2;

  typedef enum logic {
    FREE  = 1'b0,
    OWNED = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        owner_q, owner_d;
  logic [IDX_W-1:0]        ptr_q, ptr_d;
  logic [2:0]              rvalid_q, rvalid_d;
  logic [2:0]              wp_err_q, wp_err_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;

  logic                    found;
  logic [IDX_W-1:0]        win;
  logic [IDX_W-1:0]        cand;
  logic [ADDR_WIDTH-1:0]   addr_win;
  logic [DATA_WIDTH-1:0]   wdata_win;
  logic                    we_win;
  logic                    wp_hit;

  function automatic logic [IDX_W-1:0] inc3(input logic [IDX_W-1:0] i);
    return (i == IDX_W'(2)) ? IDX_W'(0) : IDX_W'(i + IDX_W'(1));
  endfunction

  // Winner selection and FREE/OWNED next-state
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    found   = 1'b0;
    win     = '0;
    cand    = ptr_q;
    if (!rst) begin
      if (state_q == OWNED && req[owner_q]) begin
        found = 1'b1;
        win   = owner_q;
        if (!lock[owner_q]) begin
          state_d = FREE;
          ptr_d   = inc3(owner_q);
        end
      end else begin
        // Owner gone (or no owner): arbitrate as FREE in this same cycle
        state_d = FREE;
        for (int k = 0; k < 3; k++) begin
          if (!found && req[cand]) begin
            found = 1'b1;
            win   = cand;
          end
          cand = inc3(cand);
        end
        if (found) begin
          if (lock[win]) begin
            state_d = OWNED;
            owner_d = win;
          end else begin
            ptr_d = inc3(win);
          end
        end
      end
    end
  end

  // Datapath mux from the winner
  always_comb begin
    case (win)
      2'd1:    begin addr_win = addr1; wdata_win = wdata1; end
      2'd2:    begin addr_win = addr2; wdata_win = wdata2; end
      default: begin addr_win = addr0; wdata_win = wdata0; end
    endcase
    we_win = we[win];
    wp_hit = addr_win < ADDR_WIDTH'(WP_LIMIT);
  end

  always_comb begin
    gnt         = found ? 3'(3'b001 << win) : 3'b000;
    mem_we      = found & we_win & ~wp_hit;
    mem_addr_d  = found ? addr_win  : mem_addr_q;
    mem_wdata_d = found ? wdata_win : mem_wdata_q;
    rvalid_d    = (found && !we_win)          ? gnt : 3'b000;
    wp_err_d    = (found && we_win && wp_hit) ? gnt : 3'b000;
  end

  assign mem_addr  = mem_addr_d;
  assign mem_wdata = mem_wdata_d;
  assign rdata     = mem_rdata;

  // A response already in the pipe when reset arrives is dropped, not delivered
  assign rvalid = rvalid_q & {3{~rst}};
  assign wp_err = wp_err_q & {3{~rst}};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FREE;
      owner_q     <= '0;
      ptr_q       <= '0;
      rvalid_q    <= '0;
      wp_err_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      ptr_q       <= ptr_d;
      rvalid_q    <= rvalid_d;
      wp_err_q    <= wp_err_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: stimulus pushes expected responses, a monitor pops them.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  req, lock, we;
  logic [11:0] addr0, addr1, addr2;
  logic [7:0]  wdata0, wdata1, wdata2;
  logic [2:0]  gnt, rvalid, wp_err;
  logic [7:0]  rdata;
  logic [11:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  mem_arbiter #(.ADDR_WIDTH(12), .DATA_WIDTH(8), .WP_LIMIT(512)) dut (
    .clk(clk), .rst(rst), .req(req), .lock(lock),
    .addr0(addr0), .addr1(addr1), .addr2(addr2), .we(we),
    .wdata0(wdata0), .wdata1(wdata1), .wdata2(wdata2),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .wp_err(wp_err),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  logic [7:0] ram       [4096];
  logic [7:0] model_mem [4096];

  function automatic logic [7:0] pat(input int a);
    return 8'(a ^ (a >> 4)) ^ 8'h5A;
  endfunction

  initial begin
    for (int i = 0; i < 4096; i++) begin
      ram[i]       = pat(i);
      model_mem[i] = pat(i);
    end
  end

  // Synchronous single-port RAM: read data one cycle after the address
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  typedef struct {
    int         cyc;
    logic [2:0] rv;
    logic [2:0] err;
    logic [7:0] data;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [11:0] last_addr = '0;
  logic [7:0]  last_wdata = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Response monitor
  always @(negedge clk) begin
    exp_t e;
    if (rvalid !== 3'b000 || wp_err !== 3'b000 || (q.size() > 0 && q[0].cyc <= cyc)) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: rvalid %b wp_err %b, expected none (cycle %0d)", rvalid, wp_err, cyc);
      end else begin
        e = q.pop_front();
        chk("resp_cycle", cyc, e.cyc);
        chk("rvalid", 32'(rvalid), 32'(e.rv));
        chk("wp_err", 32'(wp_err), 32'(e.err));
        if (e.rv != 3'b000) chk("rdata", 32'(rdata), 32'(e.data));
      end
    end
  end

  task automatic clear();
    req = '0; lock = '0; we = '0;
    addr0 = '0; addr1 = '0; addr2 = '0;
    wdata0 = '0; wdata1 = '0; wdata2 = '0;
  endtask

  task automatic put(input int i, input logic w, input logic [11:0] a, input logic [7:0] d);
    req[i] = 1'b1;
    we[i]  = w;
    case (i)
      1:       begin addr1 = a; wdata1 = d; end
      2:       begin addr2 = a; wdata2 = d; end
      default: begin addr0 = a; wdata0 = d; end
    endcase
  endtask

  // One cycle: check grant/RAM port, queue expected response, advance
  task automatic step(input logic [2:0] eg, input bit push);
    int         w;
    logic [11:0] a;
    logic [7:0]  d;
    logic        ew;
    exp_t        e;
    #2;
    chk("gnt", 32'(gnt), 32'(eg));
    if (rst) chk("rst_rvalid", 32'(rvalid), 32'd0);
    if (eg == 3'b000) begin
      chk("mem_we_idle", 32'(mem_we), 32'd0);
      chk("mem_addr_hold", 32'(mem_addr), 32'(last_addr));
      chk("mem_wdata_hold", 32'(mem_wdata), 32'(last_wdata));
    end else begin
      w = eg[1] ? 1 : (eg[2] ? 2 : 0);
      a = (w == 1) ? addr1 : ((w == 2) ? addr2 : addr0);
      d = (w == 1) ? wdata1 : ((w == 2) ? wdata2 : wdata0);
      ew = we[w] && (a >= 12'h200);
      chk("mem_we", 32'(mem_we), 32'(ew));
      chk("mem_addr", 32'(mem_addr), 32'(a));
      chk("mem_wdata", 32'(mem_wdata), 32'(d));
      last_addr  = a;
      last_wdata = d;
      if (push) begin
        e.cyc = cyc + 1; e.rv = 3'b000; e.err = 3'b000; e.data = 8'h00;
        if (we[w] && a < 12'h200) begin
          e.err = eg;
          q.push_back(e);
        end else if (we[w]) begin
          model_mem[a] = d;
        end else begin
          e.rv   = eg;
          e.data = model_mem[a];
          q.push_back(e);
        end
      end
    end
    if (rst) begin
      last_addr  = '0;
      last_wdata = '0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    clear();
    @(posedge clk);
    #1;
    // Reset: no grant or RAM write regardless of requests
    rst = 1'b1;
    put(0, 1'b1, 12'h300, 8'h11); put(1, 1'b1, 12'h301, 8'h22); put(2, 1'b1, 12'h302, 8'h33);
    step(3'b000, 1'b0);
    step(3'b000, 1'b0);
    rst = 1'b0;
    clear();
    chk("reset_rvalid", 32'(rvalid), 32'd0);
    chk("reset_wp_err", 32'(wp_err), 32'd0);
    step(3'b000, 1'b0);

    // Round robin from ptr=0 with all requesting
    clear();
    put(0, 1'b0, 12'h010, 8'h00); put(1, 1'b0, 12'h020, 8'h00); put(2, 1'b0, 12'h030, 8'h00);
    step(3'b001, 1'b1);
    step(3'b010, 1'b1);
    step(3'b100, 1'b1);
    step(3'b001, 1'b1);

    // Font-space read and top-of-memory read
    clear(); put(1, 1'b0, 12'h050, 8'h00); step(3'b010, 1'b1);
    clear(); put(0, 1'b0, 12'hFFF, 8'h00); step(3'b001, 1'b1);

    // Protected write, permitted write, then read both back
    clear(); put(2, 1'b1, 12'h1FF, 8'hAA); step(3'b100, 1'b1);
    clear(); put(2, 1'b1, 12'h200, 8'h3C); step(3'b100, 1'b1);
    clear(); put(2, 1'b0, 12'h1FF, 8'h00); step(3'b100, 1'b1);
    clear(); put(2, 1'b0, 12'h200, 8'h00); step(3'b100, 1'b1);
    clear(); step(3'b000, 1'b0);

    // Two-byte locked read by req0 while req1 waits
    clear(); put(0, 1'b0, 12'h200, 8'h00); put(1, 1'b0, 12'h040, 8'h00); lock = 3'b001;
    step(3'b001, 1'b1);
    addr0 = 12'h201;
    step(3'b001, 1'b1);
    clear(); put(1, 1'b0, 12'h040, 8'h00);
    step(3'b010, 1'b1);

    // Owner drops lock with req held: final grant, then resume at owner+1
    clear();
    put(0, 1'b0, 12'h100, 8'h00); put(1, 1'b0, 12'h101, 8'h00); put(2, 1'b0, 12'h102, 8'h00);
    lock = 3'b100;
    step(3'b100, 1'b1);
    step(3'b100, 1'b1);
    lock = 3'b000;
    step(3'b100, 1'b1);
    step(3'b001, 1'b1);
    step(3'b010, 1'b1);

    // Reset while req0 owns the lock with a read in flight
    clear(); put(0, 1'b0, 12'h010, 8'h00); lock = 3'b001;
    step(3'b001, 1'b1);
    addr0 = 12'h011;
    step(3'b001, 1'b0);
    rst = 1'b1;
    put(1, 1'b0, 12'h050, 8'h00);
    step(3'b000, 1'b0);
    rst = 1'b0;
    clear();
    chk("post_rst_rvalid", 32'(rvalid), 32'd0);
    put(1, 1'b0, 12'h050, 8'h00);
    step(3'b010, 1'b1);
    clear();
    put(0, 1'b0, 12'h020, 8'h00); put(1, 1'b0, 12'h021, 8'h00); put(2, 1'b0, 12'h022, 8'h00);
    step(3'b100, 1'b1);

    clear();
    step(3'b000, 1'b0);
    step(3'b000, 1'b0);
    step(3'b000, 1'b0);
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 12, SHALL set the program/data memory address width.
REQ-002 Parameter DATA_WIDTH, default 8, SHALL set the memory byte width.
REQ-003 Parameter WP_LIMIT, default 512, SHALL set the write-protect boundary; addresses below it are interpreter/font space.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset. Ports are listed below as name, direction, width, meaning.
REQ-005 clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 req  in  3  per-requester access request; 0 = instruction fetch, 1 = sprite/draw, 2 = register load/store.
REQ-008 lock  in  3  per-requester hold; while the owner asserts it, the grant is held for multi-byte accesses.
REQ-009 addr0, addr1, addr2  in  ADDR_WIDTH each  per-requester byte address.
REQ-010 we  in  3  per-requester write enable.
REQ-011 wdata0, wdata1, wdata2  in  DATA_WIDTH each  per-requester write data.
REQ-012 gnt  out  3  one-hot grant; the access is issued in the cycle gnt is high.
REQ-013 rvalid  out  3  per-requester read data valid.
REQ-014 rdata  out  DATA_WIDTH  shared read data, equal to mem_rdata.
REQ-015 wp_err  out  3  per-requester write-protect violation pulse.
REQ-016 mem_addr  out  ADDR_WIDTH  address to the single-port RAM.
REQ-017 mem_we  out  1  RAM write enable.
REQ-018 mem_wdata  out  DATA_WIDTH  RAM write data.
REQ-019 mem_rdata  in  DATA_WIDTH  RAM read data, valid one cycle after its address is presented.

Function
REQ-020 gnt SHALL be combinational from req, the owner register and the priority pointer; at most one bit is high per cycle, and only where the matching req bit is high.
REQ-021 With no owner, the first requesting index starting at ptr, then ptr+1 mod 3, then ptr+2 mod 3, SHALL win.
REQ-022 ptr SHALL update to (winner+1) mod 3 on every grant cycle where the winner does not assert lock.
REQ-023 State machine FREE/OWNED: FREE->OWNED when the winner asserts lock (owner := winner); OWNED holds while req[owner] and lock[owner] are both high; OWNED->FREE on the first cycle either drops.
REQ-024 On that releasing cycle: if req[owner]=1, the owner still SHALL receive its final grant and ptr := owner+1 mod 3; if req[owner]=0, arbitration proceeds as FREE in the same cycle.
REQ-025 In OWNED, only the owner SHALL be granted; other requesters wait with gnt=0, without timeout.
REQ-026 mem_addr and mem_wdata SHALL mux from the winner; with no grant they SHALL hold their last values and mem_we=0.
REQ-027 mem_we = we[winner] AND (addr_winner >= WP_LIMIT).
REQ-028 A granted write with addr < WP_LIMIT SHALL be suppressed, still receive gnt, and pulse wp_err[winner] one cycle later for exactly one cycle.
REQ-029 Reads of any address SHALL be allowed, including font space below WP_LIMIT.
REQ-030 Read latency: a granted read in cycle N SHALL give rvalid[winner]=1 and rdata valid in cycle N+1 only.
REQ-031 Granted writes SHALL never raise rvalid.
REQ-032 Back-to-back grants to any requesters SHALL be sustained at one access per cycle.
REQ-033 Addresses SHALL be used unmodified; no wrap or increment is done by this block, so 0xFFF is a valid address.

Reset
REQ-034 Reset SHALL set ptr=0, state FREE, rvalid=0, wp_err=0, mem_addr=0 and mem_wdata=0.
REQ-035 gnt and mem_we SHALL be 0 while rst is high, whatever req is.
REQ-036 A reset asserted mid-lock SHALL drop ownership, and any read issued in the cycle before reset SHALL NOT produce rvalid after reset.

Verification
REQ-037 Scenario: req=3'b111 held, no lock, from reset -> gnt sequence 001, 010, 100, 001; each read gives rvalid one cycle later.
REQ-038 Scenario: req0 reads 0x200 with lock=1 for 2 cycles (addr 0x200, 0x201) while req1=1 -> gnt0 for 2 cycles, then gnt1; rdata returns RAM[0x200], RAM[0x201].
REQ-039 Scenario: req2 writes 0x1FF with data 0xAA -> gnt2=1, mem_we=0, wp_err[2] pulses next cycle, RAM[0x1FF] unchanged; a write to 0x200 sets mem_we=1.
REQ-040 Scenario: req1 reads font byte 0x050 -> rvalid[1] next cycle, rdata=RAM[0x050], wp_err=0.
REQ-041 Scenario: rst asserted while req0 owns the lock with a read in flight -> the next cycle has rvalid=0 and gnt=0; after release, req1 alone is granted immediately with ptr=0 priority.
REQ-042 Scenario: owner drops lock with req still high -> one final owner grant, then round-robin resumes from owner+1.
